tilt_monitor: RTL
=================

TILT_MONITOR -- requirements
Module: tilt_monitor

Interface
REQ-001 SHALL have parameter N_CH, 3, number of accelerometer axes processed.
REQ-002 SHALL have parameter DATA_W, 16, signed sample width per channel.
REQ-003 SHALL have parameter ANG_W, 20, signed angle width in tenths of a degree.
REQ-004 SHALL have parameter EMA_SHIFT, 2, EMA alpha = 2^-EMA_SHIFT.
REQ-005 SHALL have parameter ALARM_ON, 400, alarm set threshold on |angle|.
REQ-006 SHALL have parameter ALARM_OFF, 350, alarm clear threshold on |angle|; requires ALARM_OFF < ALARM_ON.
REQ-007 SHALL have port clk  in  1  system clock; one clock, reset is synchronous and active-high.
REQ-008 SHALL have port reset  in  1  synchronous active-high reset.
REQ-009 SHALL have port s_valid  in  1  sample vector valid.
REQ-010 SHALL have port s_ready  out  1  block accepts sample vector.
REQ-011 SHALL have port s_data  in  N_CH*DATA_W  packed signed samples, channel 0 in LSBs.
REQ-012 SHALL have port freeze  in  1  hold all outputs and refuse input.
REQ-013 SHALL have port out_valid  out  1  one-cycle pulse, new angles available.
REQ-014 SHALL have port angle  out  N_CH*ANG_W  packed filtered angles.
REQ-015 SHALL have port alarm  out  N_CH  per-channel alarm with hysteresis.
REQ-016 SHALL have port buzzer  out  1  square-wave tone output.

Function
REQ-017 SHALL run FSM IDLE -> CALC -> UPDATE -> IDLE; s_ready = (state==IDLE) && !freeze.
REQ-018 SHALL capture s_data into an internal register on s_valid && s_ready and enter CALC with channel index 0.
REQ-019 SHALL in CALC process one channel per cycle using a single shared multiplier: scaled = (900*x) >>> 8 (arithmetic shift, rounds toward minus infinity), sign-extended to ANG_W.
REQ-020 SHALL update filter per channel: f <= f - (f >>> EMA_SHIFT) + (scaled >>> EMA_SHIFT), arithmetic in ANG_W+1 bits, saturated to ANG_W.
REQ-021 SHALL leave CALC after channel N_CH-1 and enter UPDATE; out_valid SHALL pulse in UPDATE, so latency from accept to out_valid is N_CH+1 cycles.
REQ-022 SHALL evaluate alarms in UPDATE: alarm[i] set when |f_i| >= ALARM_ON, cleared when |f_i| < ALARM_OFF, otherwise held; |most negative value| saturates to the maximum positive value.
REQ-023 SHALL compute max_abs over channels with alarm set and select buzzer half-period HP from the band table: [ALARM_ON,+100)->12500, +100..+199->10000, +200..+299->8333, +300..+399->7143, +400..+499->6250, >= +500->5000 cycles.
REQ-024 SHALL toggle buzzer when the tone counter reaches HP-1, then reset the counter to 0, giving a period of 2*HP; with no alarm, buzzer and counter SHALL be 0.
REQ-025 SHALL, when freeze asserts during CALC or UPDATE, finish the current vector, then hold angle and alarm; buzzer continues from held alarms.
REQ-026 SHALL ignore s_valid outside IDLE; no sample is lost while s_ready is low because the source holds it.

Reset
REQ-027 SHALL on reset clear all filter states, angle, alarm, out_valid, buzzer and the tone counter to 0, set s_ready to 1 on the next cycle, and force state IDLE, aborting any vector mid-CALC without an out_valid pulse.

Configuration
REQ-028 SHALL with TILT_MON_BUZZER_EN defined include the tone generator of REQ-023/024; without it, buzzer SHALL be tied to 0 and no tone counter logic exists.

Structure
REQ-029 SHALL place the FSM state typedef, scale constants (900, shift 8) and the band/half-period table in package tilt_monitor_pkg.
REQ-030 SHALL implement the tone generator as sub-module tilt_tone_gen (inputs: clk, reset, enable, half_period; output: buzzer).

Verification
REQ-031 SHALL cover: reset, then s_data ch0=256 and others 0 -> out_valid 4 cycles after accept, angle0=225; same again -> 394.
REQ-032 SHALL cover: ch1=-256 once from reset -> angle1=-225; alarm1=0.
REQ-033 SHALL cover hysteresis: drive f0 up to >=400 -> alarm0=1; decay to 370 -> still 1; decay to 349 -> 0.
REQ-034 SHALL cover buzzer: steady ch0=256 until f0 settles near 900 -> buzzer toggles every 5000 cycles; with the macro undefined, buzzer stays 0.
REQ-035 SHALL cover freeze: assert freeze mid-CALC -> out_valid pulses once, then s_ready=0, and angle is unchanged under continued s_valid.
REQ-036 SHALL cover reset mid-CALC: no out_valid, all angles 0, s_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/tilt_monitor_pkg.sv
// Shared definitions for the tilt monitor.
// - state_t: sequencing FSM states
// - SCALE_MUL / SCALE_SHIFT: raw sample to tenths-of-degree scaling, (900*x) >>> 8
// - BAND_HP: buzzer half-period per 100-count band above the alarm-on threshold
package tilt_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  localparam int SCALE_MUL   = 900;
  localparam int SCALE_SHIFT = 8;

  localparam int BAND_STEP = 100;
  localparam int HP_W      = 14;
  localparam int N_BANDS   = 6;
  localparam int unsigned BAND_HP [N_BANDS] = '{12500, 10000, 8333, 7143, 6250, 5000};

  // excess = max |angle| above the alarm-on threshold (0 if not above it)
  function automatic logic [HP_W-1:0] band_half_period(input int unsigned excess);
    logic [HP_W-1:0] hp;
    hp = HP_W'(BAND_HP[N_BANDS-1]);
    for (int b = N_BANDS - 2; b >= 0; b--) begin
      if (excess < int'((b + 1) * BAND_STEP)) hp = HP_W'(BAND_HP[b]);
    end
    return hp;
  endfunction

endpackage

// File: rtl/tilt_tone_gen.sv
// Square-wave tone generator for the tilt alarm buzzer.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   enable       - tone on while high; when low, counter and buzzer are held at 0
//   half_period  - cycles per buzzer half-period
//   buzzer       - square-wave output, period 2*half_period
module tilt_tone_gen
  import tilt_monitor_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [HP_W-1:0] half_period,
  output logic            buzzer
);

  logic [HP_W-1:0] cnt;

  // >= rather than == so a shrinking half-period never strands the counter
  // above the new terminal count.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      cnt    <= '0;
      buzzer <= 1'b0;
    end else if (cnt >= half_period - HP_W'(1)) begin
      cnt    <= '0;
      buzzer <= ~buzzer;
    end else begin
      cnt <= cnt + HP_W'(1);
    end
  end

endmodule

// File: rtl/tilt_monitor.sv
// Tilt monitor: scales accelerometer samples to tenths of a degree, EMA-filters
// each channel, raises per-channel alarms with hysteresis and drives a buzzer
// whose pitch rises with the largest alarmed tilt.
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   s_valid/s_ready    - sample vector handshake; s_data packs N_CH signed samples, ch0 in LSBs
//   freeze             - refuse new vectors (in-flight vector still completes)
//   out_valid          - one-cycle pulse when angle/alarm are refreshed
//   angle              - packed filtered angles, ch0 in LSBs
//   alarm              - per-channel alarm
//   buzzer             - tone output
// Build option: define TILT_MON_BUZZER_EN to include the tone generator;
// otherwise buzzer is tied to 0.
//
// state     | meaning
// ST_IDLE   | waiting for a sample vector
// ST_CALC   | filtering one channel per cycle through the shared multiplier
// ST_UPDATE | publishing angles, evaluating alarms, pulsing out_valid
module tilt_monitor
  import tilt_monitor_pkg::*;
#(
  parameter int N_CH      = 3,
  parameter int DATA_W    = 16,
  parameter int ANG_W     = 20,
  parameter int EMA_SHIFT = 2,
  parameter int ALARM_ON  = 400,
  parameter int ALARM_OFF = 350
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [N_CH*DATA_W-1:0]   s_data,
  input  logic                     freeze,
  output logic                     out_valid,
  output logic [N_CH*ANG_W-1:0]    angle,
  output logic [N_CH-1:0]          alarm,
  output logic                     buzzer
);

  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PROD_W = DATA_W + 11;   // 900 needs 11 signed bits

  localparam logic signed [PROD_W-1:0] MUL_K  = PROD_W'(SCALE_MUL);
  localparam logic signed [ANG_W-1:0]  F_MAX  = {1'b0, {(ANG_W-1){1'b1}}};
  localparam logic signed [ANG_W-1:0]  F_MIN  = {1'b1, {(ANG_W-1){1'b0}}};
  localparam logic [ANG_W-1:0]         ON_TH  = ANG_W'(ALARM_ON);
  localparam logic [ANG_W-1:0]         OFF_TH = ANG_W'(ALARM_OFF);

  state_t state, state_nxt;

  logic [CH_W-1:0]           ch_idx;
  logic [N_CH*DATA_W-1:0]    sample_q;
  logic signed [ANG_W-1:0]   filt [N_CH];

  logic signed [DATA_W-1:0]  x_sel;
  logic signed [PROD_W-1:0]  prod;
  logic signed [PROD_W-1:0]  prod_sh;
  logic signed [ANG_W-1:0]   scaled;
  logic signed [ANG_W-1:0]   f_cur;
  logic signed [ANG_W:0]     f_sum;
  logic signed [ANG_W-1:0]   f_sat;
  logic [ANG_W-1:0]          abs_filt [N_CH];
  logic [N_CH-1:0]           alarm_nxt;
  logic                      last_ch;

  assign s_ready = (state == ST_IDLE) && !freeze;
  assign last_ch = (ch_idx == CH_W'(N_CH - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (s_valid && s_ready) state_nxt = ST_CALC;
      ST_CALC:   if (last_ch) state_nxt = ST_UPDATE;
      ST_UPDATE: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Shared multiplier: one channel per CALC cycle.
  assign x_sel   = sample_q[int'(ch_idx)*DATA_W +: DATA_W];
  assign prod    = PROD_W'(x_sel) * MUL_K;
  assign prod_sh = prod >>> SCALE_SHIFT;
  assign scaled  = ANG_W'(prod_sh);
  assign f_cur   = filt[ch_idx];

  always_comb begin
    f_sum = (ANG_W+1)'(f_cur) - (ANG_W+1)'(f_cur >>> EMA_SHIFT)
          + (ANG_W+1)'(scaled >>> EMA_SHIFT);
    if (f_sum[ANG_W] != f_sum[ANG_W-1]) f_sat = f_sum[ANG_W] ? F_MIN : F_MAX;
    else                                f_sat = f_sum[ANG_W-1:0];
  end

  // |F_MIN| is not representable, so it saturates to F_MAX.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      if (filt[i] == F_MIN)        abs_filt[i] = F_MAX;
      else if (filt[i][ANG_W-1])   abs_filt[i] = -filt[i];
      else                         abs_filt[i] = filt[i];
    end
  end

  always_comb begin
    alarm_nxt = alarm;
    for (int i = 0; i < N_CH; i++) begin
      if (abs_filt[i] >= ON_TH)       alarm_nxt[i] = 1'b1;
      else if (abs_filt[i] < OFF_TH)  alarm_nxt[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ch_idx    <= '0;
      sample_q  <= '0;
      out_valid <= 1'b0;
      angle     <= '0;
      alarm     <= '0;
      for (int i = 0; i < N_CH; i++) filt[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (s_valid && s_ready) begin
            sample_q <= s_data;
            ch_idx   <= '0;
          end
        end
        ST_CALC: begin
          filt[ch_idx] <= f_sat;
          ch_idx       <= ch_idx + CH_W'(1);
        end
        ST_UPDATE: begin
          out_valid <= 1'b1;
          alarm     <= alarm_nxt;
          for (int i = 0; i < N_CH; i++) angle[i*ANG_W +: ANG_W] <= filt[i];
        end
        default: ;
      endcase
    end
  end

`ifdef TILT_MON_BUZZER_EN
  logic [ANG_W-1:0] max_abs;
  logic [ANG_W-1:0] excess;
  logic [HP_W-1:0]  hp_q;

  // Pitch follows the largest tilt among channels whose alarm will be set;
  // a held alarm below the on-threshold uses the lowest band.
  always_comb begin
    max_abs = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (alarm_nxt[i] && (abs_filt[i] > max_abs)) max_abs = abs_filt[i];
    end
    excess = (max_abs > ON_TH) ? (max_abs - ON_TH) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset)                   hp_q <= '0;
    else if (state == ST_UPDATE) hp_q <= band_half_period(32'(excess));
  end

  tilt_tone_gen u_tone (
    .clk         (clk),
    .reset       (reset),
    .enable      (|alarm),
    .half_period (hp_q),
    .buzzer      (buzzer)
  );
`else
  assign buzzer = 1'b0;
`endif

endmodule
